// File: rtl/io_delay_unit.sv
// Execution-side responder for the Delay/Entrada/Saida instruction bits: timed delays,
// button-confirmed switch capture and display latching, with core stall generation.
module io_delay_unit #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned SW_W        = 16,
    parameter int unsigned DELAY_SCALE = 50000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              delay_req,
    input  logic              in_req,
    input  logic              out_req,
    input  logic [DATA_W-1:0] op_data,
    input  logic [SW_W-1:0]   sw,
    input  logic              btn_confirm,
    output logic              stall,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] disp_data,
    output logic              wait_led
);

    localparam int unsigned PRE_W = (DELAY_SCALE > 1) ? $clog2(DELAY_SCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_RELOAD = PRE_W'(DELAY_SCALE - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DELAY   = 2'd1,
        WAIT_IN = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0][SW_W-1:0] sw_pipe;
    logic [SYNC_STAGES-1:0]           btn_pipe;
    logic [SW_W-1:0]                  sw_sync;
    logic                             btn_sync;
    logic                             btn_prev;
    logic                             btn_rise;

    logic [DATA_W-1:0] units;
    logic [PRE_W-1:0]  pre;
    logic              done_in;

    logic take_delay;
    logic take_zero;
    logic take_in;
    logic take_out;
    logic delay_last;

    // Synchronizers for the asynchronous board inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_pipe  <= '0;
            btn_pipe <= '0;
            btn_prev <= 1'b0;
        end else begin
            sw_pipe  <= {sw_pipe[SYNC_STAGES-2:0], sw};
            btn_pipe <= {btn_pipe[SYNC_STAGES-2:0], btn_confirm};
            btn_prev <= btn_sync;
        end
    end

    assign sw_sync  = sw_pipe[SYNC_STAGES-1];
    assign btn_sync = btn_pipe[SYNC_STAGES-1];
    assign btn_rise = btn_sync & ~btn_prev;

    // Request decode in IDLE; delay outranks input, input outranks output
    always_comb begin
        take_delay = 1'b0;
        take_zero  = 1'b0;
        take_in    = 1'b0;
        take_out   = 1'b0;
        if (state == IDLE) begin
            if (delay_req) begin
                take_delay = (op_data != '0);
                take_zero  = (op_data == '0);
            end else if (in_req) begin
                take_in = 1'b1;
            end else if (out_req) begin
                take_out = 1'b1;
            end
        end
    end

    assign delay_last = (pre == '0) && (units == DATA_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (take_delay) begin
                    state_nxt = DELAY;
                end else if (take_in) begin
                    state_nxt = WAIT_IN;
                end
            end
            DELAY: begin
                if (delay_last) begin
                    state_nxt = DONE;
                end
            end
            WAIT_IN: begin
                if (btn_rise) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Stall must cover the request cycle itself, so it is decoded from live requests in IDLE
    always_comb begin
        stall    = 1'b0;
        wait_led = 1'b0;
        rd_valid = 1'b0;
        case (state)
            IDLE: begin
                stall = take_delay | take_in;
            end
            DELAY: begin
                stall = 1'b1;
            end
            WAIT_IN: begin
                stall    = 1'b1;
                wait_led = 1'b1;
            end
            DONE: begin
                rd_valid = done_in;
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

    // Delay counters, capture and display registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            units     <= '0;
            pre       <= '0;
            done_in   <= 1'b0;
            rd_data   <= '0;
            disp_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_in <= 1'b0;
                    if (take_delay) begin
                        units <= op_data;
                        pre   <= PRE_RELOAD;
                    end
                    if (take_out) begin
                        disp_data <= op_data;
                    end
                end
                DELAY: begin
                    if (pre == '0) begin
                        pre   <= PRE_RELOAD;
                        units <= units - DATA_W'(1);
                    end else begin
                        pre <= pre - PRE_W'(1);
                    end
                end
                WAIT_IN: begin
                    if (btn_rise) begin
                        rd_data <= DATA_W'(sw_sync);
                        done_in <= 1'b1;
                    end
                end
                default: begin
                    done_in <= done_in;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_delay_unit.sv
// Directed self-checking bench for io_delay_unit with a short delay scale.
module tb_io_delay_unit;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned SW_W        = 16;
    localparam int unsigned DELAY_SCALE = 4;
    localparam int unsigned SYNC_STAGES = 2;

    logic              clk;
    logic              rst_n;
    logic              delay_req;
    logic              in_req;
    logic              out_req;
    logic [DATA_W-1:0] op_data;
    logic [SW_W-1:0]   sw;
    logic              btn_confirm;
    logic              stall;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [DATA_W-1:0] disp_data;
    logic              wait_led;

    int checks;
    int errors;

    io_delay_unit #(
        .DATA_W     (DATA_W),
        .SW_W       (SW_W),
        .DELAY_SCALE(DELAY_SCALE),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .delay_req  (delay_req),
        .in_req     (in_req),
        .out_req    (out_req),
        .op_data    (op_data),
        .sw         (sw),
        .btn_confirm(btn_confirm),
        .stall      (stall),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .disp_data  (disp_data),
        .wait_led   (wait_led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        delay_req   = 1'b0;
        in_req      = 1'b0;
        out_req     = 1'b0;
        op_data     = '0;
        sw          = '0;
        btn_confirm = 1'b0;
        #12;
        checks++;
        if ({stall, rd_valid, wait_led} !== 3'b000 || rd_data !== 32'h0 || disp_data !== 32'h0) begin
            errors++;
            $display("FAIL reset: stall=%b rd_valid=%b wait_led=%b rd_data=%h disp_data=%h want all zero",
                     stall, rd_valid, wait_led, rd_data, disp_data);
        end
        #4 rst_n = 1'b1;
        step();
    endtask

    task automatic test_output();
        out_req = 1'b1;
        op_data = 32'h0000_00A5;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL out_stall: got %b want 0", stall);
        end
        step();
        out_req = 1'b0;
        op_data = 32'h0;
        #1;
        checks++;
        if (disp_data !== 32'h0000_00A5 || stall !== 1'b0) begin
            errors++;
            $display("FAIL out_disp: disp=%h stall=%b want 000000a5 / 0", disp_data, stall);
        end
    endtask

    task automatic test_delay();
        int cnt;
        delay_req = 1'b1;
        op_data   = 32'd3;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL delay_req_stall: got %b want 1", stall);
        end
        cnt = 1;
        step();
        delay_req = 1'b0;
        op_data   = 32'h0;
        #1;
        for (int i = 0; i < 50; i++) begin
            if (stall !== 1'b1) break;
            cnt++;
            step();
            #1;
        end
        checks++;
        if (cnt != 13) begin
            errors++;
            $display("FAIL delay_len: got %0d stalled cycles want 13", cnt);
        end
        checks++;
        if (stall !== 1'b0 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL delay_done: stall=%b rd_valid=%b want 0/0", stall, rd_valid);
        end
        step();
        checks++;
        if (stall !== 1'b0 || rd_valid !== 1'b0 || disp_data !== 32'h0000_00A5) begin
            errors++;
            $display("FAIL delay_idle: stall=%b rd_valid=%b disp=%h want 0/0/000000a5",
                     stall, rd_valid, disp_data);
        end
    endtask

    task automatic test_zero_delay();
        int bad;
        bad = 0;
        delay_req = 1'b1;
        op_data   = 32'h0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (stall !== 1'b0 || wait_led !== 1'b0) bad++;
            step();
        end
        delay_req = 1'b0;
        #1;
        checks++;
        if (bad != 0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL zero_delay: %0d cycles stalled, stall now %b want 0", bad, stall);
        end
    endtask

    task automatic test_input();
        int bad;
        btn_confirm = 1'b1;
        sw          = 16'h1234;
        repeat (4) step();
        in_req = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL in_req_stall: got %b want 1", stall);
        end
        step();
        in_req = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (stall !== 1'b1 || wait_led !== 1'b1 || rd_valid !== 1'b0) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL in_held: %0d bad cycles while button held want 0", bad);
        end
        btn_confirm = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (stall !== 1'b1 || rd_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL in_released: %0d bad cycles after release want 0", bad);
        end
        btn_confirm = 1'b1;
        step();
        step();
        checks++;
        if (rd_valid !== 1'b0 || stall !== 1'b1) begin
            errors++;
            $display("FAIL in_early: rd_valid=%b stall=%b want 0/1", rd_valid, stall);
        end
        step();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 32'h0000_1234 || stall !== 1'b0 || wait_led !== 1'b0) begin
            errors++;
            $display("FAIL in_capture: rd_valid=%b rd_data=%h stall=%b led=%b want 1/00001234/0/0",
                     rd_valid, rd_data, stall, wait_led);
        end
        sw = 16'hFFFF;
        step();
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 32'h0000_1234) begin
            errors++;
            $display("FAIL in_hold: rd_valid=%b rd_data=%h want 0/00001234", rd_valid, rd_data);
        end
        btn_confirm = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_reset_mid_delay();
        int bad;
        delay_req = 1'b1;
        op_data   = 32'd100;
        step();
        delay_req = 1'b0;
        op_data   = 32'h0;
        repeat (10) step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0 || rd_valid !== 1'b0 || disp_data !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid: stall=%b rd_valid=%b disp=%h want 0/0/0", stall, rd_valid, disp_data);
        end
        #3 rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (stall !== 1'b0 || rd_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rst_after: %0d bad cycles after reset want 0", bad);
        end
        out_req = 1'b1;
        op_data = 32'h0000_005A;
        step();
        out_req = 1'b0;
        op_data = 32'h0;
        #1;
        checks++;
        if (disp_data !== 32'h0000_005A) begin
            errors++;
            $display("FAIL rst_out: disp=%h want 0000005a", disp_data);
        end
    endtask

    task automatic test_priority();
        int cnt;
        int led;
        delay_req = 1'b1;
        in_req    = 1'b1;
        op_data   = 32'd2;
        #1;
        cnt = (stall === 1'b1) ? 1 : 0;
        led = (wait_led === 1'b1) ? 1 : 0;
        step();
        delay_req = 1'b0;
        in_req    = 1'b0;
        op_data   = 32'h0;
        #1;
        for (int i = 0; i < 50; i++) begin
            if (stall !== 1'b1) break;
            cnt++;
            if (wait_led === 1'b1) led++;
            step();
            #1;
        end
        checks++;
        if (cnt != 9 || led != 0) begin
            errors++;
            $display("FAIL prio_delay: stalled %0d want 9, wait_led cycles %0d want 0", cnt, led);
        end
        out_req = 1'b1;
        op_data = 32'h0000_0077;
        step();
        out_req = 1'b0;
        op_data = 32'h0;
        #1;
        checks++;
        if (disp_data !== 32'h0000_005A || rd_valid !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL done_ignore: disp=%h rd_valid=%b stall=%b want 0000005a/0/0",
                     disp_data, rd_valid, stall);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_output();
        test_delay();
        test_zero_delay();
        test_input();
        test_reset_mid_delay();
        test_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
